// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port 512x32 synchronous RAM.
// Grants are combinational; ownership locks and a round-robin pointer are registered.
module ram_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [3:0]  we0_i,
    input  logic [3:0]  we1_i,
    input  logic [8:0]  a0_i,
    input  logic [8:0]  a1_i,
    input  logic [31:0] di0_i,
    input  logic [31:0] di1_i,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        en,
    output logic [3:0]  we,
    output logic [8:0]  a,
    output logic [31:0] di,
    // RAM read data; 'do' is a reserved word, hence the suffix.
    input  logic [31:0] do_i
);

    typedef enum logic [1:0] {
        StFree = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } owner_e;

    owner_e owner_q, owner_d;
    logic   prio_q, prio_d;
    logic   rvalid0_q, rvalid1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= StFree;
            prio_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            rvalid0_q <= gnt0 && (we0_i == 4'h0);
            rvalid1_q <= gnt1 && (we1_i == 4'h0);
        end
    end

    // An owner that stops requesting gives up the slot in the same cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            unique case (owner_q)
                StOwn0: begin
                    if (req0) gnt0 = 1'b1;
                    else      gnt1 = req1;
                end
                StOwn1: begin
                    if (req1) gnt1 = 1'b1;
                    else      gnt0 = req0;
                end
                default: begin
                    if (req0 && (!req1 || !prio_q)) gnt0 = 1'b1;
                    else if (req1)                  gnt1 = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        owner_d = StFree;
        if (gnt0 && lock0)      owner_d = StOwn0;
        else if (gnt1 && lock1) owner_d = StOwn1;

        prio_d = prio_q;
        if (gnt0)      prio_d = 1'b1;
        else if (gnt1) prio_d = 1'b0;
    end

    always_comb begin
        en = 1'b0;
        we = 4'h0;
        a  = 9'h000;
        di = 32'h0;
        if (gnt0) begin
            en = 1'b1;
            we = we0_i;
            a  = a0_i;
            di = di0_i;
        end else if (gnt1) begin
            en = 1'b1;
            we = we1_i;
            a  = a1_i;
            di = di1_i;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = do_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of ownership, priority and memory contents.
module tb_ram_arbiter;

    logic        clk, rst_n;
    logic        req0, req1, lock0, lock1;
    logic [3:0]  we0_i, we1_i;
    logic [8:0]  a0_i, a1_i;
    logic [31:0] di0_i, di1_i;
    logic        gnt0, gnt1, rvalid0, rvalid1, en;
    logic [31:0] rdata, di, ram_do;
    logic [3:0]  we;
    logic [8:0]  a;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0_i(we0_i), .we1_i(we1_i), .a0_i(a0_i), .a1_i(a1_i),
        .di0_i(di0_i), .di1_i(di1_i),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .en(en), .we(we), .a(a), .di(di), .do_i(ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: 1-cycle synchronous read, byte-enabled write.
    logic [31:0] mem [512];
    logic [31:0] mem_tmp;
    always @(posedge clk) begin
        if (en) begin
            if (we != 4'h0) begin
                mem_tmp = mem[a];
                for (int b = 0; b < 4; b++)
                    if (we[b]) mem_tmp[8*b +: 8] = di[8*b +: 8];
                mem[a] <= mem_tmp;
            end
            ram_do <= mem[a];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner (-1 free), round-robin pointer, expected read returns, shadow memory.
    int          m_owner;
    int          m_prio;
    logic        m_rv0, m_rv1;
    logic [31:0] m_rdata;
    logic [31:0] shadow [512];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        if (m_owner == 0 && req0) return 0;
        if (m_owner == 1 && req1) return 1;
        if (req0 && req1) return m_prio;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_prio  = 0;
        m_rv0   = 1'b0;
        m_rv1   = 1'b0;
    endtask

    // Apply inputs just after the edge and check everything before the next one.
    task automatic drive(input logic r0, input logic r1, input logic l0, input logic l1,
                         input logic [3:0] w0, input logic [3:0] w1,
                         input logic [8:0] ad0, input logic [8:0] ad1,
                         input logic [31:0] d0, input logic [31:0] d1);
        int g;
        req0 = r0; req1 = r1; lock0 = l0; lock1 = l1;
        we0_i = w0; we1_i = w1; a0_i = ad0; a1_i = ad1; di0_i = d0; di1_i = d1;
        #3;
        g = winner();
        chk("gnt0", gnt0, g == 0);
        chk("gnt1", gnt1, g == 1);
        chk("en", en, g >= 0);
        chk("we", we, g == 0 ? w0 : g == 1 ? w1 : 4'h0);
        chk("a", a, g == 0 ? ad0 : g == 1 ? ad1 : 9'h0);
        chk("di", di, g == 0 ? d0 : g == 1 ? d1 : 32'h0);
        chk("rvalid0", rvalid0, m_rv0);
        chk("rvalid1", rvalid1, m_rv1);
        if (m_rv0 || m_rv1) chk("rdata", rdata, m_rdata);
    endtask

    task automatic tick();
        int g;
        logic [3:0]  w;
        logic [8:0]  ad;
        logic [31:0] d;
        g = winner();
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        if (g >= 0) begin
            w  = (g == 0) ? we0_i : we1_i;
            ad = (g == 0) ? a0_i  : a1_i;
            d  = (g == 0) ? di0_i : di1_i;
            if (w == 4'h0) begin
                m_rdata = shadow[ad];
                if (g == 0) m_rv0 = 1'b1;
                else        m_rv1 = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (w[b]) shadow[ad][8*b +: 8] = d[8*b +: 8];
            end
            m_prio = (g == 0) ? 1 : 0;
        end
        if (g == 0 && lock0)      m_owner = 0;
        else if (g == 1 && lock1) m_owner = 1;
        else                      m_owner = -1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 4'h0, 4'h0, 9'h0, 9'h0, 32'h0, 32'h0);
        tick();
    endtask

    // Inputs are held busy during reset to show they are ignored.
    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1; req1 = 1; lock0 = 1; lock1 = 1;
        we0_i = 4'hF; we1_i = 4'h0; a0_i = 9'h1AB; a1_i = 9'h0CD;
        di0_i = 32'h12345678; di1_i = 32'h9ABCDEF0;
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_en", en, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_we", we, 4'h0);
        chk("rst_a", a, 9'h0);
        chk("rst_di", di, 32'h0);
        chk("rst_en2", en, 1'b0);
        model_reset();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        do_reset();

        // Write then read back through requester 0.
        drive(1, 0, 0, 0, 4'hF, 4'h0, 9'h010, 9'h0, 32'hDEADBEEF, 32'h0);
        chk("wr_gnt0", gnt0, 1'b1);
        chk("wr_we", we, 4'hF);
        chk("wr_a", a, 9'h010);
        tick();
        drive(1, 0, 0, 0, 4'h0, 4'h0, 9'h010, 9'h0, 32'h0, 32'h0);
        chk("wr_no_rvalid", rvalid0, 1'b0);
        tick();
        drive(0, 0, 0, 0, 4'h0, 4'h0, 9'h0, 9'h0, 32'h0, 32'h0);
        chk("rd_rvalid0", rvalid0, 1'b1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        tick();

        // Preload low addresses through requester 1.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 0, 4'h0, 4'hF, 9'h0, 9'(i), 32'h0, $urandom);
            tick();
        end

        // Contention without lock alternates starting with requester 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 4'h0, 4'h0, 9'(i + 1), 9'(i + 9), 32'h0, 32'h0);
            chk("alt_gnt0", gnt0, (i % 2) == 0);
            tick();
        end
        idle();

        // Requester 1 locks while requester 0 keeps asking.
        do_reset();
        drive(1, 0, 0, 0, 4'h0, 4'h0, 9'h3, 9'h0, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 4'h0, 4'h0, 9'h2, 9'(i + 4), 32'h0, 32'h0);
            chk("lock_gnt1", gnt1, 1'b1);
            tick();
        end
        drive(1, 1, 0, 0, 4'h0, 4'h0, 9'h2, 9'h7, 32'h0, 32'h0);
        tick();
        drive(1, 1, 0, 0, 4'h0, 4'h0, 9'h2, 9'h8, 32'h0, 32'h0);
        chk("unlock_gnt0", gnt0, 1'b1);
        tick();
        idle();

        // Owner 0 stops requesting with lock still high: requester 1 gets the slot.
        do_reset();
        drive(1, 0, 1, 0, 4'h0, 4'h0, 9'h6, 9'h0, 32'h0, 32'h0);
        tick();
        drive(0, 1, 1, 0, 4'h0, 4'h0, 9'h6, 9'h7, 32'h0, 32'h0);
        chk("release_gnt1", gnt1, 1'b1);
        tick();
        idle();

        // Reset right after a granted read kills the pending rvalid.
        drive(1, 0, 1, 0, 4'h0, 4'h0, 9'h5, 9'h0, 32'h0, 32'h0);
        tick();
        chk("pre_rst_rvalid0", rvalid0, 1'b1);
        do_reset();
        idle();
        drive(1, 1, 0, 0, 4'h0, 4'h0, 9'h5, 9'h6, 32'h0, 32'h0);
        chk("post_rst_gnt0", gnt0, 1'b1);
        tick();

        // Random traffic on the preloaded window.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] w0, w1;
            w0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            w1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  w0, w1, 9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
                  $urandom, $urandom);
            tick();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters: none; address width fixed at 9 (512 words), data width fixed at 32, byte-enable width fixed at 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0 / req1  input  1  requester N asks for one RAM access this cycle.
REQ-005 lock0 / lock1  input  1  requester N keeps ownership after the current granted access.
REQ-006 we0_i / we1_i  input  4  byte write enables; 4'b0000 = read.
REQ-007 a0_i / a1_i  input  9  word address.
REQ-008 di0_i / di1_i  input  32  write data.
REQ-009 gnt0 / gnt1  output  1  access of requester N issued to RAM this cycle.
REQ-010 rvalid0 / rvalid1  output  1  rdata valid for requester N.
REQ-011 rdata  output  32  read data, shared by both requesters, qualified by rvalidN.
REQ-012 en  output  1  RAM enable.
REQ-013 we  output  4  RAM byte write enables.
REQ-014 a  output  9  RAM address.
REQ-015 di  output  32  RAM write data.
REQ-016 do  input  32  RAM read data; valid the cycle after a read is issued (1-cycle synchronous read).

Function
REQ-017 At most one of gnt0/gnt1 SHALL be high in any cycle; gntN implies reqN is high in the same cycle.
REQ-018 Grant SHALL be combinational from the current req/lock inputs and the registered state; zero-cycle arbitration latency.
REQ-019 State: owner register with states FREE, OWN0, OWN1; 1-bit priority pointer prio (0 favours requester 0).
REQ-020 In FREE: if exactly one requester requests, it is granted; if both request, the requester selected by prio is granted.
REQ-021 In OWNn: only requester n can be granted; the other requester's request is held off (gnt low) regardless of prio.
REQ-022 Owner transitions on each clock edge: if gntN and lockN are high, the next state is OWNN; if in OWNn and reqn is low, the next state is FREE; otherwise, the next state is FREE.
REQ-023 After every cycle with gntN high, prio SHALL point to the other requester; prio is unchanged in cycles with no grant.
REQ-024 With gntN high: en=1, we=weN_i, a=aN_i, di=diN_i. With no grant: en=0, we=0, a=0, di=0.
REQ-025 A granted read (weN_i==0) SHALL set rvalidN high for exactly the next cycle; rdata=do in that cycle.
REQ-026 A granted write SHALL NOT produce rvalid.
REQ-027 Back-to-back reads by one owner SHALL produce rvalid on consecutive cycles (full throughput, 1 access per cycle).
REQ-028 rdata SHALL equal do at all times; only rvalidN qualifies it.
REQ-029 Both requesters asserting lock while in FREE: only the granted one takes ownership.

Reset
REQ-030 While rst_n is low: owner=FREE, prio=0, rvalid0=rvalid1=0, gnt0=gnt1=0, en=0, we=0, a=0, di=0, regardless of inputs.
REQ-031 Reset asserted mid-transaction SHALL immediately drop any pending rvalid and release any lock; no access is issued in the first cycle after rst_n rises unless a req is present then.

Verification
REQ-032 Reset, then req0=1 we0_i=4'hF a0_i=9'h010 di0_i=32'hDEADBEEF for 1 cycle -> gnt0=1, en=1, we=4'hF, a=9'h010; no rvalid0; then req0 read at 9'h010 -> rvalid0=1 next cycle, rdata=32'hDEADBEEF.
REQ-033 Both req0 and req1 high for 4 cycles, reads at distinct addresses, no lock -> grants alternate 0,1,0,1 starting with 0 after reset; each rvalid follows its grant by one cycle.
REQ-034 req1+lock1 high for 3 cycles while req0 high -> gnt1 for all 3 cycles, gnt0 low; lock1 dropped -> the next cycle grants requester 0 (prio=0).
REQ-035 Owner OWN0 and req0 drops while lock0 is still high -> owner returns to FREE; a pending req1 is granted that same cycle.
REQ-036 rst_n pulsed low in the cycle after a granted read -> rvalid0 forced to 0 asynchronously; after release, owner=FREE, prio=0.
REQ-037 Continuous assertion: gnt0&gnt1 never high; en==(gnt0|gnt1); rvalidN only after a read grant to requester N.
